// File: rtl/uart_tx_arbiter.sv
// Packet-granular round-robin arbiter that shares one UART transmitter between
// NUM_REQ byte sources, gating every byte start on the host CTS line.
module uart_tx_arbiter #(
  parameter int unsigned NUM_REQ    = 2,
  parameter int unsigned GAP_CYCLES = 16
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [NUM_REQ-1:0]   req,
  input  logic [NUM_REQ*8-1:0] pkt_len,
  input  logic [NUM_REQ*8-1:0] req_data,
  input  logic                 laptop_can_receive,
  input  logic                 uart_data_sent,
  output logic                 send_uart_data,
  output logic [7:0]           uart_data_tx,
  output logic [NUM_REQ-1:0]   byte_ack,
  output logic [NUM_REQ-1:0]   pkt_done,
  output logic [NUM_REQ-1:0]   grant,
  output logic                 busy,
  output logic [31:0]          bytes_sent
);

  localparam int unsigned PTR_W = $clog2(NUM_REQ);
  localparam int unsigned GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  localparam logic [PTR_W:0]   NREQ_W   = (PTR_W+1)'(NUM_REQ);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(NUM_REQ - 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LOAD = 2'd1;
  localparam logic [1:0] S_SEND = 2'd2;
  localparam logic [1:0] S_GAP  = 2'd3;

  logic [1:0]         r_state;
  logic [PTR_W-1:0]   r_rr_ptr;
  logic [PTR_W-1:0]   r_gidx;
  logic [NUM_REQ-1:0] r_grant;
  logic [NUM_REQ-1:0] r_pkt_done;
  logic [7:0]         r_remaining;
  logic [GAP_W-1:0]   r_gap;
  logic [7:0]         r_tx;
  logic [31:0]        r_bytes_sent;

  logic               w_found;
  logic [PTR_W-1:0]   w_winner;
  logic [PTR_W-1:0]   w_next_ptr;
  logic [PTR_W:0]     w_idx;
  logic [NUM_REQ-1:0] w_onehot;
  logic [7:0]         w_len;
  logic [7:0]         w_data;
  logic               w_ack;

  // Scan starting at r_rr_ptr, wrapping modulo NUM_REQ (works for non-power-of-two counts).
  always_comb begin
    w_found  = 1'b0;
    w_winner = '0;
    w_idx    = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      w_idx = {1'b0, r_rr_ptr} + (PTR_W+1)'(i);
      if (w_idx >= NREQ_W) w_idx = w_idx - NREQ_W;
      if (!w_found && req[w_idx[PTR_W-1:0]]) begin
        w_found  = 1'b1;
        w_winner = w_idx[PTR_W-1:0];
      end
    end
  end

  assign w_next_ptr = (w_winner == PTR_LAST) ? '0 : w_winner + PTR_W'(1);
  assign w_onehot   = {{(NUM_REQ-1){1'b0}}, 1'b1} << w_winner;
  assign w_len      = pkt_len[{w_winner, 3'b000} +: 8];
  assign w_data     = req_data[{r_gidx, 3'b000} +: 8];
  assign w_ack      = (r_state == S_LOAD) && laptop_can_receive;

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_state      <= S_IDLE;
      r_rr_ptr     <= '0;
      r_gidx       <= '0;
      r_grant      <= '0;
      r_pkt_done   <= '0;
      r_remaining  <= '0;
      r_gap        <= '0;
      r_tx         <= '0;
      r_bytes_sent <= '0;
    end else begin
      r_pkt_done <= '0;
      case (r_state)
        S_IDLE: begin
          if (w_found) begin
            r_rr_ptr    <= w_next_ptr;
            r_gidx      <= w_winner;
            r_remaining <= w_len;
            // Zero-length requests are retired without ever owning the transmitter.
            if (w_len == '0) begin
              r_pkt_done <= w_onehot;
              r_gap      <= '0;
              r_state    <= S_GAP;
            end else begin
              r_grant <= w_onehot;
              r_state <= S_LOAD;
            end
          end
        end
        S_LOAD: begin
          if (laptop_can_receive) begin
            r_tx    <= w_data;
            r_state <= S_SEND;
          end
        end
        S_SEND: begin
          if (uart_data_sent) begin
            r_bytes_sent <= r_bytes_sent + 32'd1;
            if (r_remaining <= 8'd1) begin
              r_remaining <= '0;
              r_pkt_done  <= r_grant;
              r_grant     <= '0;
              r_gap       <= '0;
              r_state     <= S_GAP;
            end else begin
              r_remaining <= r_remaining - 8'd1;
              r_state     <= S_LOAD;
            end
          end
        end
        S_GAP: begin
          if (r_gap == GAP_LAST) r_state <= S_IDLE;
          else                   r_gap   <= r_gap + GAP_W'(1);
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign send_uart_data = (r_state == S_SEND);
  assign uart_data_tx   = r_tx;
  assign byte_ack       = w_ack ? r_grant : '0;
  assign pkt_done       = r_pkt_done;
  assign grant          = r_grant;
  assign busy           = (r_state != S_IDLE);
  assign bytes_sent     = r_bytes_sent;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: two byte sources, a simple uart_tcvr
// responder, and hand-computed expectations checked with immediate assertions.
module tb_uart_tx_arbiter;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [1:0]  req = '0;
  logic [15:0] pkt_len = '0;
  logic [15:0] req_data;
  logic        cts = 1'b1;
  logic        uart_data_sent;
  logic        send_uart_data;
  logic [7:0]  uart_data_tx;
  logic [1:0]  byte_ack, pkt_done, grant;
  logic        busy;
  logic [31:0] bytes_sent;

  uart_tx_arbiter #(.NUM_REQ(2), .GAP_CYCLES(16)) dut (
    .clock(clock), .reset(reset), .req(req), .pkt_len(pkt_len),
    .req_data(req_data), .laptop_can_receive(cts),
    .uart_data_sent(uart_data_sent), .send_uart_data(send_uart_data),
    .uart_data_tx(uart_data_tx), .byte_ack(byte_ack), .pkt_done(pkt_done),
    .grant(grant), .busy(busy), .bytes_sent(bytes_sent)
  );

  always #5 clock = ~clock;

  int n_vec = 0;
  int n_err = 0;

  // Source 0 byte k: 0x01 for k=0, else 10*k; source 1 byte k: 0x80+k.
  function automatic logic [7:0] src0(input logic [4:0] i);
    return (i == 5'd0) ? 8'h01 : 8'(int'(i) * 10);
  endfunction
  function automatic logic [7:0] src1(input logic [4:0] i);
    return 8'h80 + {3'b000, i};
  endfunction

  logic       clr = 1'b1;
  logic       resp_en = 1'b1;
  logic       man_sent = 1'b0;
  logic       resp_pulse = 1'b0;
  int         resp_cnt = 0;
  logic [4:0] idx0 = '0, idx1 = '0;
  int         ack0 = 0, ack1 = 0, done0 = 0, done1 = 0;
  logic       send_seen = 1'b0;
  logic [7:0] log_q[$];
  int         done_q[$];

  assign req_data       = {src1(idx1), src0(idx0)};
  assign uart_data_sent = resp_pulse | man_sent;

  always @(posedge clock) begin
    if (clr) begin
      idx0 <= '0; idx1 <= '0; ack0 <= 0; ack1 <= 0; done0 <= 0; done1 <= 0;
      send_seen <= 1'b0;
      log_q.delete();
      done_q.delete();
    end else begin
      if (byte_ack[0]) begin idx0 <= idx0 + 5'd1; ack0 <= ack0 + 1; end
      if (byte_ack[1]) begin idx1 <= idx1 + 5'd1; ack1 <= ack1 + 1; end
      if (pkt_done[0]) begin done0 <= done0 + 1; done_q.push_back(0); end
      if (pkt_done[1]) begin done1 <= done1 + 1; done_q.push_back(1); end
      if (send_uart_data) send_seen <= 1'b1;
      if (send_uart_data && uart_data_sent) log_q.push_back(uart_data_tx);
    end
  end

  // Transmitter stand-in: completes each byte about 10 cycles after send rises.
  always @(posedge clock) begin
    resp_pulse <= 1'b0;
    if (!resp_en || !send_uart_data || resp_pulse) resp_cnt <= 0;
    else if (resp_cnt == 9) begin resp_pulse <= 1'b1; resp_cnt <= 0; end
    else resp_cnt <= resp_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  logic [7:0] e_t1[5]  = '{8'h01, 8'h0A, 8'h14, 8'h1E, 8'h28};
  logic [7:0] e_t2[13] = '{8'h80, 8'h81, 8'h82, 8'h83,
                           8'h01, 8'h0A, 8'h14, 8'h1E, 8'h28,
                           8'h84, 8'h85, 8'h86, 8'h87};
  logic [7:0] e_t3[14] = '{8'h01, 8'h0A, 8'h14, 8'h1E, 8'h28,
                           8'h80, 8'h81, 8'h82, 8'h83,
                           8'h32, 8'h3C, 8'h46, 8'h50, 8'h5A};

  task automatic clear_env();
    clr = 1'b1;
    @(negedge clock);
    clr = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    for (int c = 0; c < 200 && busy; c++) @(negedge clock);
    chk(tag, 32'(busy), 32'd0);
  endtask

  task automatic wait_dones(input string tag, input int n);
    for (int c = 0; c < 3000 && done_q.size() < n; c++) @(negedge clock);
    chk(tag, 32'(done_q.size()), 32'(n));
  endtask

  initial begin
    logic bad;
    logic got;
    int   c;

    // Reset state
    repeat (3) @(negedge clock);
    chk("rst_grant", 32'(grant), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_send", 32'(send_uart_data), 32'd0);
    chk("rst_tx", 32'(uart_data_tx), 32'd0);
    chk("rst_bytes", bytes_sent, 32'd0);
    chk("rst_ack", 32'(byte_ack), 32'd0);
    chk("rst_done", 32'(pkt_done), 32'd0);
    reset = 1'b1;
    clr   = 1'b0;
    @(negedge clock);

    // Single 5-byte packet from source 0
    pkt_len = {8'd0, 8'd5};
    req     = 2'b01;
    @(negedge clock);
    chk("t1_grant", 32'(grant), 32'd1);
    chk("t1_first_ack", 32'(byte_ack), 32'd1);
    chk("t1_busy", 32'(busy), 32'd1);
    req = 2'b00;
    @(negedge clock);
    chk("t1_send_latency", 32'(send_uart_data), 32'd1);
    bad = 1'b0;
    got = 1'b0;
    for (int k = 0; k < 1000; k++) begin
      @(negedge clock);
      if (pkt_done[0]) begin got = 1'b1; break; end
      if (grant !== 2'b01) bad = 1'b1;
    end
    chk("t1_done_seen", 32'(got), 32'd1);
    chk("t1_grant_held", 32'(bad), 32'd0);
    chk("t1_done_vec", 32'(pkt_done), 32'd1);
    c = 0;
    while (busy && c < 100) begin @(negedge clock); c++; end
    chk("t1_gap_cycles", 32'(c), 32'd16);
    chk("t1_acks", 32'(ack0), 32'd5);
    chk("t1_dones", 32'(done0), 32'd1);
    chk("t1_nbytes", 32'(log_q.size()), 32'd5);
    for (int i = 0; i < 5; i++) chk($sformatf("t1_byte%0d", i), 32'(log_q[i]), 32'(e_t1[i]));
    chk("t1_bytes_sent", bytes_sent, 32'd5);

    // Round-robin pointer now at 1: simultaneous requests start with source 1
    clear_env();
    pkt_len = {8'd4, 8'd5};
    req     = 2'b11;
    @(negedge clock);
    chk("t2_rr_first", 32'(grant), 32'd2);
    wait_dones("t2_done_count", 3);
    req = 2'b00;
    chk("t2_order0", 32'(done_q[0]), 32'd1);
    chk("t2_order1", 32'(done_q[1]), 32'd0);
    chk("t2_order2", 32'(done_q[2]), 32'd1);
    wait_idle("t2_idle");
    chk("t2_nbytes", 32'(log_q.size()), 32'd13);
    for (int i = 0; i < 13; i++) chk($sformatf("t2_byte%0d", i), 32'(log_q[i]), 32'(e_t2[i]));
    chk("t2_bytes_sent", bytes_sent, 32'd18);

    // Contention from reset: packets alternate 0,1,0 with no interleaving
    reset = 1'b0;
    clr   = 1'b1;
    repeat (2) @(negedge clock);
    reset = 1'b1;
    clr   = 1'b0;
    req   = 2'b11;
    wait_dones("t3_done_count", 3);
    req = 2'b00;
    chk("t3_order0", 32'(done_q[0]), 32'd0);
    chk("t3_order1", 32'(done_q[1]), 32'd1);
    chk("t3_order2", 32'(done_q[2]), 32'd0);
    wait_idle("t3_idle");
    chk("t3_nbytes", 32'(log_q.size()), 32'd14);
    for (int i = 0; i < 14; i++) chk($sformatf("t3_byte%0d", i), 32'(log_q[i]), 32'(e_t3[i]));
    chk("t3_bytes_sent", bytes_sent, 32'd14);

    // CTS stall after the second byte is acknowledged
    clear_env();
    pkt_len = {8'd0, 8'd5};
    req     = 2'b01;
    @(negedge clock);
    req = 2'b00;
    for (int k = 0; k < 500 && ack0 < 2; k++) @(negedge clock);
    chk("t4_two_acks", 32'(ack0), 32'd2);
    cts = 1'b0;
    bad = 1'b0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clock);
      if (byte_ack !== 2'b00) bad = 1'b1;
    end
    chk("t4_no_ack_stalled", 32'(bad), 32'd0);
    chk("t4_inflight_done", 32'(log_q.size()), 32'd2);
    chk("t4_stall_bytes", bytes_sent, 32'd16);
    chk("t4_stall_send", 32'(send_uart_data), 32'd0);
    chk("t4_stall_grant", 32'(grant), 32'd1);
    cts = 1'b1;
    #1;
    chk("t4_resume_ack", 32'(byte_ack), 32'd1);
    wait_dones("t4_done_count", 1);
    wait_idle("t4_idle");
    chk("t4_acks", 32'(ack0), 32'd5);
    chk("t4_nbytes", 32'(log_q.size()), 32'd5);
    for (int i = 0; i < 5; i++) chk($sformatf("t4_byte%0d", i), 32'(log_q[i]), 32'(e_t1[i]));
    chk("t4_bytes_sent", bytes_sent, 32'd19);

    // Zero-length request from source 1
    clear_env();
    pkt_len = {8'd0, 8'd5};
    req     = 2'b10;
    @(negedge clock);
    chk("t5_done_pulse", 32'(pkt_done), 32'd2);
    chk("t5_grant", 32'(grant), 32'd0);
    req = 2'b00;
    wait_idle("t5_idle");
    chk("t5_dones", 32'(done1), 32'd1);
    chk("t5_acks", 32'(ack0 + ack1), 32'd0);
    chk("t5_send_seen", 32'(send_seen), 32'd0);
    chk("t5_bytes_sent", bytes_sent, 32'd19);

    // Reset while the third of five bytes is in flight
    clear_env();
    pkt_len = {8'd0, 8'd5};
    req     = 2'b01;
    @(negedge clock);
    req = 2'b00;
    for (int k = 0; k < 500 && ack0 < 3; k++) @(negedge clock);
    chk("t6_three_acks", 32'(ack0), 32'd3);
    chk("t6_in_send", 32'(send_uart_data), 32'd1);
    resp_en = 1'b0;
    reset   = 1'b0;
    @(negedge clock);
    chk("t6_grant", 32'(grant), 32'd0);
    chk("t6_busy", 32'(busy), 32'd0);
    chk("t6_send", 32'(send_uart_data), 32'd0);
    chk("t6_tx", 32'(uart_data_tx), 32'd0);
    chk("t6_bytes", bytes_sent, 32'd0);
    chk("t6_ack", 32'(byte_ack), 32'd0);
    reset = 1'b1;
    @(negedge clock);
    man_sent = 1'b1;
    @(negedge clock);
    man_sent = 1'b0;
    repeat (3) @(negedge clock);
    chk("t6_late_sent_bytes", bytes_sent, 32'd0);
    chk("t6_no_done", 32'(done0), 32'd0);
    chk("t6_idle", 32'(busy), 32'd0);
    resp_en = 1'b1;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares the single UART transmitter (uart_tcvr) between NUM_REQ packet sources, e.g. the face-result stream (requester 0) and the clock-count telemetry stream (requester 1).
- Grants are packet-granular and round-robin: once a packet starts, no other requester's bytes interleave with it.
- Gates every byte start on the host's CTS line.
- Sits between the result/telemetry FSMs and uart_tcvr in top.

Parameters:
NUM_REQ, 2, number of requesters (2..8)
GAP_CYCLES, 16, idle cycles enforced after each packet before the next grant (min 1)

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-low reset
req  in  NUM_REQ  request per source; sampled only in IDLE
pkt_len  in  NUM_REQ x 8  byte count of the requested packet; sampled with the grant
req_data  in  NUM_REQ x 8  current byte of each source; must be valid while the source is granted
laptop_can_receive  in  1  host CTS; 1 = host may receive
uart_data_sent  in  1  one-cycle pulse from uart_tcvr when the byte is transmitted
send_uart_data  out  1  to uart_tcvr; held high until uart_data_sent
uart_data_tx  out  8  byte to uart_tcvr; registered
byte_ack  out  NUM_REQ  one-cycle pulse: granted source's byte consumed, advance to next
pkt_done  out  NUM_REQ  one-cycle pulse: packet finished (also for a dropped zero-length request)
grant  out  NUM_REQ  one-hot owner of the transmitter; 0 when idle
busy  out  1  state != IDLE
bytes_sent  out  32  total bytes transmitted since reset; wraps at 2^32

Behaviour:
- Reset (reset==0 at a clock edge): state=IDLE; rr_ptr=0; all outputs 0 (uart_data_tx=8'd0, send_uart_data=0, bytes_sent=0).
- Reset mid-packet aborts immediately. No pkt_done is issued. The aborted byte's uart_data_sent, if it arrives later, is ignored.
- States: IDLE, LOAD, SEND, GAP.
- IDLE:
  - If req != 0, pick the first asserted index scanning rr_ptr, rr_ptr+1, ... (mod NUM_REQ). Set grant to that index; set rr_ptr = winner+1 (mod NUM_REQ).
  - Latch remaining = pkt_len[winner].
  - If pkt_len == 0: pulse pkt_done[winner] next cycle, send no bytes, go to GAP.
  - Otherwise go to LOAD.
- LOAD:
  - If laptop_can_receive == 1: uart_data_tx <= req_data[grant]; pulse byte_ack[grant]; go to SEND.
  - Otherwise stay in LOAD. No ack is issued while CTS is low.
- SEND:
  - send_uart_data = 1 and uart_data_tx is stable.
  - On uart_data_sent: bytes_sent++ and remaining--.
    - If remaining was 1: pulse pkt_done[grant], clear grant, go to GAP.
    - Otherwise go to LOAD.
  - CTS dropping during SEND does not abort the byte in flight. It only blocks the next LOAD.
- GAP: count GAP_CYCLES cycles, then go to IDLE. Requests arriving during GAP wait.
- Latency:
  - req high in IDLE at cycle N: grant at N+1.
  - With CTS high: byte_ack at N+1 and send_uart_data at N+2.
  - Byte-to-byte: 1 LOAD cycle after each uart_data_sent.
- Ordering: bytes within a packet are sent in ack order. A grant is never revoked; req deassertion mid-packet is ignored.
- Simultaneous requests: round-robin fairness. With both requesters asserted continuously, packets alternate 0,1,0,1...
- Width rules: pkt_len max 255. remaining is 8 bits and never underflows. rr_ptr is clog2(NUM_REQ) bits.
- Invariant: grant is one-hot or zero at all times.
- Invariant: send_uart_data is high only in SEND.

Test Plan:
- Single packet: req=01, pkt_len[0]=5, data bytes 0x01,0x0A,0x14,0x1E,0x28, CTS=1, uart_data_sent 10 cycles after each send -> exactly 5 byte_ack[0] pulses, tx bytes in that order, one pkt_done[0], bytes_sent=5, grant=01 throughout, GAP of 16 cycles before busy=0.
- Contention: req=11 held, pkt_len 5 and 4 -> order is packet0, packet1, packet0, and no byte of one requester appears between bytes of the other.
- Round-robin pointer: after a req0 grant, assert req=11 in the same cycle -> req1 is granted first.
- CTS stall: deassert laptop_can_receive after byte 2 is acked -> byte 2 completes, LOAD holds with no ack while CTS=0, and resumes within 1 cycle of CTS=1. Total bytes are unchanged.
- Zero length: req=10, pkt_len[1]=0 -> pkt_done[1] pulses once, no byte_ack, send_uart_data stays 0, bytes_sent unchanged.
- Reset mid-packet: assert reset=0 while in SEND on byte 3 of 5 -> next cycle all outputs are 0 and state is IDLE. A late uart_data_sent does not change bytes_sent, and no pkt_done is issued.
